// File: rtl/mem_pkg.sv
// Shared types and defaults for the load/store memory access controller.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

    localparam logic [31:0] MEM_ADDR_BASE = 32'd1024;
    localparam int unsigned MEM_ADDR_W    = 16;
    localparam int unsigned MEM_TIMEOUT   = 255;

endpackage

// File: rtl/mem_wait_timer.sv
// ACCESS-cycle counter with clear/enable; expire fires on the LIMIT-th enabled cycle.
module mem_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between execute stage and data memory (IDLE->ACCESS->DONE).
// Optional access timeout with sticky mem_err: define MEM_TIMEOUT_EN.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = MEM_ADDR_BASE,
    parameter int unsigned ADDR_W    = MEM_ADDR_W,
    parameter int unsigned TIMEOUT   = MEM_TIMEOUT
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [31:0]       alu_res,
    input  logic [31:0]       val_rm,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       rdata,
    output logic              freeze,
    output logic              mem_err
);

    mem_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       off_w;
    logic              req_in;
    logic              expire;

    assign off_w  = alu_res - ADDR_BASE;
    assign req_in = mem_r_en | mem_w_en;

`ifdef MEM_TIMEOUT_EN
    mem_wait_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rest),
        .clr_i    (state_q != ACCESS),
        .en_i     (state_q == ACCESS),
        .expire_o (expire)
    );
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign expire         = 1'b0;
`endif

    logic unused_off;
    assign unused_off = ^{off_w[1:0], off_w[31:ADDR_W+2], err_q};

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_in) begin
                    state_d = ACCESS;
                    we_d    = mem_w_en;
                    addr_d  = off_w[ADDR_W+1:2];
                    wdata_d = val_rm;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = mem_rdata;
                end else if (expire) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (!we_q) rdata_d = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Gated by rest so an in-reset pipeline is never stalled.
    assign freeze    = rest && (((state_q == IDLE) && req_in) || (state_q == ACCESS));
    assign mem_req   = (state_q == ACCESS);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
`ifdef MEM_TIMEOUT_EN
    assign mem_err   = err_q;
`else
    assign mem_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against a transaction-level model.
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rest = 1'b0;
    logic        mem_r_en = 1'b0, mem_w_en = 1'b0;
    logic [31:0] alu_res = '0, val_rm = '0;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] rdata;
    logic        freeze, mem_err;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(
        .ADDR_BASE (32'd1024),
        .ADDR_W    (16),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rest      (rest),
        .mem_r_en  (mem_r_en),
        .mem_w_en  (mem_w_en),
        .alu_res   (alu_res),
        .val_rm    (val_rm),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .rdata     (rdata),
        .freeze    (freeze),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    // Reference: one outstanding transaction plus a one-cycle cool-down flag.
    bit          m_busy, m_cool, m_we, m_err;
    logic [15:0] m_addr;
    logic [31:0] m_wdata, m_rdata;
    int          m_wait;
    int          req_pulses;
    bit          prev_req;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_cool = 0; m_we = 0; m_err = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_wait = 0;
    endtask

    function automatic logic [15:0] word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return 16'((off / 4) % 65536);
    endfunction

    task automatic step(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit ack,
                        input logic [31:0] rd);
        bit want_freeze;
        mem_r_en = r; mem_w_en = w; alu_res = a; val_rm = d;
        mem_ack = ack; mem_rdata = rd;
        #4;
        want_freeze = m_busy || (!m_cool && (r || w));
        check("mem_req", 32'(mem_req), 32'(m_busy));
        check("freeze", 32'(freeze), 32'(want_freeze));
        check("rdata", rdata, m_rdata);
        check("mem_err", 32'(mem_err), 32'(m_err));
        if (m_busy) begin
            check("mem_we", 32'(mem_we), 32'(m_we));
            check("mem_addr", 32'(mem_addr), 32'(m_addr));
            if (m_we) check("mem_wdata", mem_wdata, m_wdata);
        end
        if (mem_req && !prev_req) req_pulses++;
        prev_req = mem_req;
        @(posedge clk);
        if (m_busy) begin
            m_wait++;
            if (ack) begin
                m_busy = 0; m_cool = 1;
                if (!m_we) m_rdata = rd;
            end
`ifdef MEM_TIMEOUT_EN
            else if (m_wait == TO) begin
                m_busy = 0; m_cool = 1; m_err = 1;
                if (!m_we) m_rdata = '0;
            end
`endif
        end else if (m_cool) begin
            m_cool = 0;
        end else if (r || w) begin
            m_busy = 1; m_wait = 0;
            m_we = w; m_addr = word_of(a); m_wdata = d;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        model_reset();
        prev_req = 0;
        req_pulses = 0;
        #2;
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_err", 32'(mem_err), 32'h0);
        @(posedge clk); #1;
        rest = 1'b1;
        idle(1);

        // Read with ack on cycle 3
        step(1, 0, 32'h404, 0, 0, 0);
        step(1, 0, 32'h404, 0, 0, 0);
        step(1, 0, 32'h404, 0, 0, 0);
        step(1, 0, 32'h404, 0, 1, 32'hDEADBEEF);
        check("rd_done_freeze", 32'(freeze), 32'h0);
        step(0, 0, 0, 0, 0, 0);
        check("rd_rdata", rdata, 32'hDEADBEEF);

        // Write acked on first ACCESS cycle
        step(0, 1, 32'h400, 32'h12345678, 0, 0);
        check("wr_addr", 32'(mem_addr), 32'h0);
        check("wr_we", 32'(mem_we), 32'h1);
        step(0, 1, 32'h400, 32'h12345678, 1, 32'h55AA55AA);
        check("wr_done_req", 32'(mem_req), 32'h0);
        idle(1);
        check("wr_rdata_kept", rdata, 32'hDEADBEEF);

        // Both enables: write wins
        step(1, 1, 32'h408, 32'hCAFEF00D, 0, 0);
        check("both_addr", 32'(mem_addr), 32'h2);
        check("both_we", 32'(mem_we), 32'h1);
        step(1, 1, 32'h408, 32'hCAFEF00D, 1, 32'h11111111);
        idle(1);
        check("both_rdata", rdata, 32'hDEADBEEF);

        // Address below base wraps
        step(1, 0, 32'h0, 0, 0, 0);
        check("wrap_addr", 32'(mem_addr), 32'hFF00);
        step(0, 0, 0, 0, 1, 32'h0BADF00D);
        idle(1);

        // Back-to-back loads held across two instructions
        req_pulses = 0;
        for (int i = 0; i < 6; i++)
            step(1, 0, 32'h40C, 0, (i == 1 || i == 4), 32'(i + 32'hA0));
        idle(1);
        check("b2b_pulses", 32'(req_pulses), 32'd2);

        // Reset in ACCESS cycle 2 abandons the access
        step(1, 0, 32'h410, 0, 0, 0);
        step(1, 0, 32'h410, 0, 0, 0);
        rest = 1'b0;
        #1;
        check("arst_req", 32'(mem_req), 32'h0);
        check("arst_freeze", 32'(freeze), 32'h0);
        check("arst_rdata", rdata, 32'h0);
        model_reset();
        mem_r_en = 0;
        @(posedge clk); #1;
        rest = 1'b1;
        step(0, 0, 0, 0, 1, 32'hFFFFFFFF);
        step(0, 0, 0, 0, 0, 0);
        check("arst_ack_ign", rdata, 32'h0);

`ifdef MEM_TIMEOUT_EN
        // Timeout on a read with no ack
        for (int i = 0; i < 6; i++) step(1, 0, 32'h420, 0, 0, 0);
        idle(1);
        check("to_err", 32'(mem_err), 32'h1);
        check("to_rdata", rdata, 32'h0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, w, ack;
            logic [31:0] a;
            r = ($urandom_range(0, 2) == 0);
            w = ($urandom_range(0, 3) == 0);
            ack = ($urandom_range(0, 2) == 0);
            a = ($urandom_range(0, 7) == 0) ? $urandom()
                : 32'h400 + 32'($urandom_range(0, 8191));
            step(r, w, a, $urandom(), ack, $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 1024, the byte address mapped to word 0 of data memory.
REQ-002 SHALL have parameter ADDR_W, default 16, the word-address width driven to memory.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum ACCESS cycles before abort (used only with MEM_TIMEOUT_EN).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rest  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mem_r_en  in  1  load request from the execute stage.
REQ-007 SHALL have port mem_w_en  in  1  store request from the execute stage.
REQ-008 SHALL have port alu_res  in  32  byte address from the execute stage.
REQ-009 SHALL have port val_rm  in  32  store data from the execute stage.
REQ-010 SHALL have port mem_req  out  1  memory request, level, held until ack.
REQ-011 SHALL have port mem_we  out  1  1 = write, 0 = read; valid while mem_req.
REQ-012 SHALL have port mem_addr  out  ADDR_W  word address.
REQ-013 SHALL have port mem_wdata  out  32  store data.
REQ-014 SHALL have port mem_rdata  in  32  load data; valid with mem_ack.
REQ-015 SHALL have port mem_ack  in  1  single-cycle completion strobe.
REQ-016 SHALL have port rdata  out  32  registered load result to writeback.
REQ-017 SHALL have port freeze  out  1  pipeline stall request.
REQ-018 SHALL have port mem_err  out  1  sticky timeout flag (tied 0 without MEM_TIMEOUT_EN).

Function
REQ-019 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE.
REQ-020 IDLE: on (mem_r_en|mem_w_en), SHALL latch address, data and direction, then go to ACCESS next edge.
REQ-021 SHALL compute mem_addr = ((alu_res - ADDR_BASE) >> 2)[ADDR_W-1:0]; alu_res[1:0] ignored; subtraction wraps modulo 2^32.
REQ-022 When mem_r_en and mem_w_en are both 1, SHALL perform a write and leave rdata unchanged.
REQ-023 ACCESS: mem_req SHALL be 1, with mem_we/mem_addr/mem_wdata stable from the latched values; on mem_ack SHALL go to DONE.
REQ-024 On a read ack, SHALL register mem_rdata into rdata at that edge; rdata SHALL otherwise hold its value.
REQ-025 DONE: mem_req SHALL be 0 and freeze SHALL be 0 for exactly one cycle; the still-present request inputs SHALL NOT start a new access; next state SHALL be IDLE.
REQ-026 freeze SHALL equal (IDLE & (mem_r_en|mem_w_en)) | ACCESS, combinationally.
REQ-027 Latency: request in IDLE at cycle 0 and ack at cycle k (k>=1) SHALL give mem_req high in cycles 1..k, DONE and freeze=0 at cycle k+1.
REQ-028 mem_ack outside ACCESS SHALL be ignored.

Reset
REQ-029 rest=0 SHALL immediately force state IDLE, with mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, mem_err=0 and timer=0, including during ACCESS (the access is abandoned).
REQ-030 On reset release, no access SHALL start before the first rising clk edge.

Configuration
REQ-031 With MEM_TIMEOUT_EN defined: the timer SHALL count ACCESS cycles; if it reaches TIMEOUT without ack, the block SHALL go to DONE, set mem_err (sticky until reset), load rdata=0 on reads, and drop mem_req.
REQ-032 Without MEM_TIMEOUT_EN: there SHALL be no timer; ACCESS SHALL wait indefinitely; mem_err SHALL be constant 0.

Structure
REQ-033 Package mem_pkg SHALL hold the FSM state enum (IDLE, ACCESS, DONE) and the default ADDR_BASE/ADDR_W constants.
REQ-034 SHALL instantiate one sub-module mem_wait_timer (clear/enable/expire counter), present only under MEM_TIMEOUT_EN.

Verification
REQ-035 Read: alu_res=0x404, mem_r_en=1, ack in cycle 3 with mem_rdata=0xDEADBEEF -> mem_addr=1, mem_we=0, freeze high cycles 0-3, rdata=0xDEADBEEF at cycle 4.
REQ-036 Write: alu_res=0x400, val_rm=0x12345678, mem_w_en=1, ack in cycle 1 -> mem_addr=0, mem_we=1, mem_wdata=0x12345678, DONE at cycle 2, rdata unchanged.
REQ-037 Both enables with alu_res=0x408 -> write to word 2 only.
REQ-038 Reset asserted in ACCESS cycle 2 -> mem_req=0 and freeze=0 immediately; a later ack is ignored.
REQ-039 MEM_TIMEOUT_EN, TIMEOUT=4, no ack -> mem_req drops after 4 ACCESS cycles, mem_err=1, rdata=0.
REQ-040 Back-to-back loads held for two instructions -> exactly two mem_req pulses with one DONE cycle between them.
